pulse_to_level: RTL and testbench
=================================

// Module: pulse_to_level
// PURPOSE
//  Inverse of the edge-to-pulse stage. Converts 1-cycle event pulses into held levels, for
//  example CPU-side UART tx_start strobes or rx_done strobes.
//  - Each pulse becomes a level that stays high for at least MIN_HOLD cycles and until ack.
//  - Each level is followed by a 1-cycle low gap, so a downstream edge detector sees one
//    rising edge per event.
//  - Pulses that arrive while busy are queued in a saturating pending counter.
// PARAMETERS
//  MIN_HOLD  4     minimum cycles level_out stays high per event (>=1)
//  CNT_W     4     pending counter width; capacity is 2**CNT_W-1 queued events
//  TIMEOUT   1024  max cycles spent in WAIT_ACK (used only with the macro)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous active-low reset
//  pulse_in     in   1      event strobe, 1 cycle per event
//  ack          in   1      consumer has taken the event (level or pulse accepted)
//  clr_ovf      in   1      clears the sticky overflow flag
//  level_out    out  1      held level toward the consumer
//  pending      out  CNT_W  queued events not yet presented
//  busy         out  1      FSM is not in IDLE
//  overflow     out  1      sticky: a pulse was lost because pending was saturated
//  timeout_flag out  1      1-cycle strobe when WAIT_ACK times out (macro only)
// BEHAVIOUR
//  Reset values (rst=0, asynchronous): all outputs 0; state=IDLE; hold_cnt=0; ack_seen=0.
//  All outputs are registered.
//  FSM states: IDLE, HOLD, WAIT_ACK, GAP.
//  IDLE:
//   - level_out=0.
//   - pulse_in=1 -> HOLD; level_out=1 from the next edge (latency 1 cycle).
//  HOLD:
//   - level_out=1; hold_cnt counts 0..MIN_HOLD-1.
//   - ack during HOLD sets ack_seen.
//   - At hold_cnt==MIN_HOLD-1: if ack_seen|ack -> GAP, else -> WAIT_ACK.
//  WAIT_ACK:
//   - level_out=1; ack=1 -> GAP.
//  GAP:
//   - level_out=0 for exactly 1 cycle; ack_seen cleared.
//   - pending>0 -> HOLD and pending-=1; else -> IDLE.
//  Pending counter:
//   - pulse_in while state!=IDLE -> +1.
//   - Increment and decrement in the same cycle -> unchanged.
//   - At 2**CNT_W-1, a further pulse is dropped, pending holds, and overflow is set.
//   - overflow stays set until clr_ovf=1. If clr_ovf and a new overflow coincide, set wins.
//  pulse_in in IDLE starts HOLD directly and is not counted. Pulse and ack in the same
//  cycle are both honoured.
//  Reset asserted mid-operation: immediate return to IDLE; pending and queued events are
//  discarded.
// CONFIGURATION
//  PULSE_TO_LEVEL_TIMEOUT_EN defined:
//   - A WAIT_ACK counter runs. After TIMEOUT cycles in WAIT_ACK with no ack:
//     go to GAP and pulse timeout_flag=1 for 1 cycle.
//   - ack on the TIMEOUT-th cycle counts as an ack, and no flag is raised.
//  PULSE_TO_LEVEL_TIMEOUT_EN undefined:
//   - WAIT_ACK waits indefinitely.
//   - timeout_flag is tied to 0, and no timeout counter is synthesised.
// STRUCTURE
//  Package p2l_pkg:
//   - typedef enum logic [1:0] p2l_state_e {IDLE, HOLD, WAIT_ACK, GAP}.
//   - HOLD_W = $clog2(MIN_HOLD+1) helper function.
//  Sub-module sat_updown_counter (WIDTH param; inc, dec, clr inputs; q, sat outputs):
//   - Implements the pending counter.
//   - Its sat output qualified by inc drives the overflow set.
//  Top level contains the FSM, hold_cnt, ack_seen and the optional timeout counter.
// TESTING (MIN_HOLD=4, CNT_W=2, TIMEOUT=8)
//  1. Single pulse at cycle 0, ack=1 at cycle 2:
//     level_out=1 cycles 1-4, 0 at cycle 5, IDLE at 6, busy 1-5.
//  2. Single pulse, ack withheld until cycle 10 (macro off):
//     level_out=1 cycles 1-10, GAP at 11, IDLE at 12.
//  3. Four pulses on cycles 0,1,2,3 with ack held 1:
//     pending reaches 3, three back-to-back 4-high/1-low levels follow, pending ends 0,
//     overflow=0.
//  4. Five pulses on cycles 0,1,2,3,4:
//     pending saturates at 3, overflow=1 and stays 1; clr_ovf=1 one cycle -> overflow=0.
//  5. Macro on, pulse at 0, no ack:
//     WAIT_ACK from 5, timeout_flag=1 at cycle 13, level_out=0 at 13, IDLE at 14.
//  6. rst=0 asserted mid-HOLD with pending=2:
//     outputs and pending=0 immediately; after release, pulse-to-level latency is 1 cycle.

Source files
------------

// File: rtl/pulse_to_level_pkg.sv
// rtl/pulse_to_level_pkg.sv - shared types, defaults and width helper for pulse_to_level
package p2l_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } p2l_state_e;

  localparam int P2L_DEF_MIN_HOLD = 4;
  localparam int P2L_DEF_CNT_W    = 4;
  localparam int P2L_DEF_TIMEOUT  = 1024;

  // Width of a counter that must be able to hold the value min_hold.
  function automatic int hold_w(input int min_hold);
    return $clog2(min_hold + 1);
  endfunction

endpackage

// File: rtl/pulse_to_level_if.sv
// rtl/pulse_to_level_if.sv - event/level handshake bundle between producer, pulse_to_level and consumer
interface pulse_to_level_if
  import p2l_pkg::*;
#(
  parameter int CNT_W = P2L_DEF_CNT_W
);

  logic             pulse_in;
  logic             ack;
  logic             clr_ovf;
  logic             level_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;
  logic             timeout_flag;

  modport master (
    output pulse_in, ack, clr_ovf,
    input  level_out, pending, busy, overflow, timeout_flag
  );

  modport slave (
    input  pulse_in, ack, clr_ovf,
    output level_out, pending, busy, overflow, timeout_flag
  );

endinterface

// File: rtl/pulse_to_level_sat_updown_counter.sv
// rtl/pulse_to_level_sat_updown_counter.sv - saturating up/down counter holding queued events
module sat_updown_counter
  import p2l_pkg::*;
#(
  parameter int WIDTH = P2L_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             sat
);

  localparam logic [WIDTH-1:0] Q_MAX = '1;

  assign sat = (q == Q_MAX);

  // Simultaneous inc and dec cancel; inc at full scale and dec at zero are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !dec && !sat) begin
      q <= q + 1'b1;
    end else if (dec && !inc && (q != '0)) begin
      q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_to_level.sv
// rtl/pulse_to_level.sv - event pulses to held, gap-separated levels; PULSE_TO_LEVEL_TIMEOUT_EN adds a WAIT_ACK timeout
module pulse_to_level
  import p2l_pkg::*;
#(
  parameter int MIN_HOLD = P2L_DEF_MIN_HOLD,
  parameter int CNT_W    = P2L_DEF_CNT_W,
  parameter int TIMEOUT  = P2L_DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  pulse_to_level_if.slave   bus
);

  localparam int                HOLD_W    = hold_w(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);

  if (MIN_HOLD < 1) begin : g_bad_min_hold
    $error("pulse_to_level: MIN_HOLD must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("pulse_to_level: TIMEOUT must be at least 1");
  end

  p2l_state_e        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              ack_seen, ack_seen_nxt;
  logic              level_q, level_nxt;
  logic              busy_q, busy_nxt;
  logic              ovf_q;
  logic              pend_inc, pend_dec, pend_sat, ovf_set;
  logic [CNT_W-1:0]  pend_q;
  logic              to_expire;

  // Events arriving while an earlier one is still being presented are queued.
  assign pend_inc = bus.pulse_in && (state != IDLE);
  // A pulse is only lost when the queue is full and nothing drains this cycle.
  assign ovf_set  = pend_inc && pend_sat && !pend_dec;

  sat_updown_counter #(
    .WIDTH (CNT_W)
  ) u_pending (
    .clk (clk),
    .rst (rst),
    .inc (pend_inc),
    .dec (pend_dec),
    .clr (1'b0),
    .q   (pend_q),
    .sat (pend_sat)
  );

`ifdef PULSE_TO_LEVEL_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag_q;

  // An ack on the final WAIT_ACK cycle wins over the timeout.
  assign to_expire = (state == WAIT_ACK) && !bus.ack && (to_cnt == TO_LAST);

  // Cycles spent in WAIT_ACK; restarts from zero on every visit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == WAIT_ACK) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // One-cycle strobe aligned with the GAP entered on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_flag_q <= 1'b0;
    end else begin
      to_flag_q <= to_expire;
    end
  end

  assign bus.timeout_flag = to_flag_q;
`else
  assign to_expire        = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  // State, hold counter and early-ack memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      ack_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      ack_seen <= ack_seen_nxt;
    end
  end

  // Next state, queue drain and next output values.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = '0;
    ack_seen_nxt = ack_seen;
    pend_dec     = 1'b0;
    case (state)
      IDLE: begin
        ack_seen_nxt = 1'b0;
        if (bus.pulse_in) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        hold_cnt_nxt = hold_cnt + 1'b1;
        if (bus.ack) begin
          ack_seen_nxt = 1'b1;
        end
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt_nxt = '0;
          state_nxt    = (ack_seen || bus.ack) ? GAP : WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.ack || to_expire) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        ack_seen_nxt = 1'b0;
        if (pend_q != '0) begin
          state_nxt = HOLD;
          pend_dec  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    level_nxt = (state_nxt == HOLD) || (state_nxt == WAIT_ACK);
    busy_nxt  = (state_nxt != IDLE);
  end

  // Registered outputs; a coincident overflow beats clr_ovf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_nxt;
      busy_q  <= busy_nxt;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;
  assign bus.pending   = pend_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// tb/tb_pulse_to_level.sv - directed bench for pulse_to_level (MIN_HOLD=4, CNT_W=2, TIMEOUT=8)
module tb_pulse_to_level;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pulse_to_level_if #(.CNT_W(2)) bus ();

  pulse_to_level #(
    .MIN_HOLD (4),
    .CNT_W    (2),
    .TIMEOUT  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs change just after the rising edge, checks follow at the falling edge.
  task automatic step(input logic p, input logic a, input logic c);
    @(posedge clk);
    #1;
    bus.pulse_in = p;
    bus.ack      = a;
    bus.clr_ovf  = c;
    @(negedge clk);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    bus.pulse_in = 1'b0;
    bus.ack      = 1'b0;
    bus.clr_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", {31'd0, bus.level_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_pending", {30'd0, bus.pending}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_tflag", {31'd0, bus.timeout_flag}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: single pulse, early ack at cycle 2
    step(1, 0, 0); chk("t1_c0_level", {31'd0, bus.level_out}, 32'd0);
    step(0, 0, 0); chk("t1_c1_level", {31'd0, bus.level_out}, 32'd1);
                   chk("t1_c1_busy", {31'd0, bus.busy}, 32'd1);
    step(0, 1, 0); chk("t1_c2_level", {31'd0, bus.level_out}, 32'd1);
    step(0, 0, 0); chk("t1_c3_level", {31'd0, bus.level_out}, 32'd1);
    step(0, 0, 0); chk("t1_c4_level", {31'd0, bus.level_out}, 32'd1);
    step(0, 0, 0); chk("t1_c5_level", {31'd0, bus.level_out}, 32'd0);
                   chk("t1_c5_busy", {31'd0, bus.busy}, 32'd1);
    step(0, 0, 0); chk("t1_c6_busy", {31'd0, bus.busy}, 32'd0);

    // 2: ack withheld until cycle 10
    step(1, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      step(0, 0, 0);
      chk("t2_wait_level", {31'd0, bus.level_out}, 32'd1);
      chk("t2_wait_tflag", {31'd0, bus.timeout_flag}, 32'd0);
    end
    step(0, 1, 0); chk("t2_c10_level", {31'd0, bus.level_out}, 32'd1);
    step(0, 0, 0); chk("t2_c11_level", {31'd0, bus.level_out}, 32'd0);
                   chk("t2_c11_busy", {31'd0, bus.busy}, 32'd1);
    step(0, 0, 0); chk("t2_c12_busy", {31'd0, bus.busy}, 32'd0);

    // 3: four pulses with ack held high
    for (int c = 0; c <= 3; c++) step(1, 1, 0);
    chk("t3_c3_pending", {30'd0, bus.pending}, 32'd2);
    for (int c = 4; c <= 21; c++) begin
      step(0, 1, 0);
      case (c)
        4:  begin chk("t3_c4_pending", {30'd0, bus.pending}, 32'd3);
                  chk("t3_c4_level", {31'd0, bus.level_out}, 32'd1); end
        5:  chk("t3_c5_level", {31'd0, bus.level_out}, 32'd0);
        6:  begin chk("t3_c6_level", {31'd0, bus.level_out}, 32'd1);
                  chk("t3_c6_pending", {30'd0, bus.pending}, 32'd2); end
        10: chk("t3_c10_level", {31'd0, bus.level_out}, 32'd0);
        11: chk("t3_c11_pending", {30'd0, bus.pending}, 32'd1);
        15: chk("t3_c15_level", {31'd0, bus.level_out}, 32'd0);
        16: begin chk("t3_c16_level", {31'd0, bus.level_out}, 32'd1);
                  chk("t3_c16_pending", {30'd0, bus.pending}, 32'd0); end
        20: chk("t3_c20_busy", {31'd0, bus.busy}, 32'd1);
        21: begin chk("t3_c21_busy", {31'd0, bus.busy}, 32'd0);
                  chk("t3_c21_ovf", {31'd0, bus.overflow}, 32'd0); end
        default: ;
      endcase
    end

    // 4: five pulses saturate the queue
    for (int c = 0; c <= 4; c++) step(1, 1, 0);
    chk("t4_c4_pending", {30'd0, bus.pending}, 32'd3);
    chk("t4_c4_ovf", {31'd0, bus.overflow}, 32'd0);
    for (int c = 5; c <= 21; c++) begin
      step(0, 1, 0);
      case (c)
        5:  begin chk("t4_c5_ovf", {31'd0, bus.overflow}, 32'd1);
                  chk("t4_c5_pending", {30'd0, bus.pending}, 32'd3); end
        6:  chk("t4_c6_pending", {30'd0, bus.pending}, 32'd2);
        21: begin chk("t4_c21_ovf", {31'd0, bus.overflow}, 32'd1);
                  chk("t4_c21_busy", {31'd0, bus.busy}, 32'd0); end
        default: ;
      endcase
    end
    step(0, 0, 1); chk("t4_clr_same_cycle", {31'd0, bus.overflow}, 32'd1);
    step(0, 0, 0); chk("t4_clr_done", {31'd0, bus.overflow}, 32'd0);

`ifdef PULSE_TO_LEVEL_TIMEOUT_EN
    // 5: timeout without ack
    step(1, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      step(0, 0, 0);
      chk("t5_wait_level", {31'd0, bus.level_out}, 32'd1);
      chk("t5_wait_tflag", {31'd0, bus.timeout_flag}, 32'd0);
    end
    step(0, 0, 0); chk("t5_c13_tflag", {31'd0, bus.timeout_flag}, 32'd1);
                   chk("t5_c13_level", {31'd0, bus.level_out}, 32'd0);
    step(0, 0, 0); chk("t5_c14_tflag", {31'd0, bus.timeout_flag}, 32'd0);
                   chk("t5_c14_busy", {31'd0, bus.busy}, 32'd0);

    // 5b: ack on the last allowed cycle suppresses the timeout
    step(1, 0, 0);
    for (int c = 1; c <= 11; c++) step(0, 0, 0);
    step(0, 1, 0); chk("t5b_c12_level", {31'd0, bus.level_out}, 32'd1);
    step(0, 0, 0); chk("t5b_c13_tflag", {31'd0, bus.timeout_flag}, 32'd0);
                   chk("t5b_c13_level", {31'd0, bus.level_out}, 32'd0);
    step(0, 0, 0); chk("t5b_c14_busy", {31'd0, bus.busy}, 32'd0);
`endif

    // 6: asynchronous reset mid-HOLD with two queued events
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0); chk("t6_pre_pending", {30'd0, bus.pending}, 32'd2);
                   chk("t6_pre_level", {31'd0, bus.level_out}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_level", {31'd0, bus.level_out}, 32'd0);
    chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_rst_pending", {30'd0, bus.pending}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 0, 0); chk("t6_after_c0_level", {31'd0, bus.level_out}, 32'd0);
    step(0, 1, 0); chk("t6_after_c1_level", {31'd0, bus.level_out}, 32'd1);
                   chk("t6_after_c1_pending", {30'd0, bus.pending}, 32'd0);
    for (int c = 2; c <= 6; c++) step(0, 0, 0);
    chk("t6_after_idle", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
